// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes, forwarding selects and register constants shared by the ALU and ID/EX stage
package alu_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd5
  } alu_op_t;
  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the newest in-flight value for one source register, EX/MEM over MEM/WB over register file
module forward_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic [ADDR_WIDTH-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic [ADDR_WIDTH-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output fwd_sel_t              sel,
  output logic [DATA_WIDTH-1:0] data
);
  logic ex_hit, wb_hit;
  always_comb begin
    ex_hit = exmem_reg_write && exmem_rd != ADDR_WIDTH'(ZERO_REG) && exmem_rd == rs;
    wb_hit = memwb_reg_write && memwb_rd != ADDR_WIDTH'(ZERO_REG) && memwb_rd == rs;
    sel = ex_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_RF;
    data = ex_hit ? exmem_result : wb_hit ? memwb_result : rf_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute register with result forwarding, operand select and load-use bubble insertion
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  uses_rs2_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  alu_src_i,
  input  logic                  op1_pc_i,
  input  logic [2:0]            alu_ctrl_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic [ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  valid_o,
  output logic                  load_use_o
);
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q, fwd1_data, fwd2_data;
  logic alu_src_q, op1_pc_q;
  fwd_sel_t fwd1_sel, fwd2_sel;
  logic unused_fwd;
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i || (!stall_i && load_use_o)) begin
      valid_o <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_addr_o <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
      alu_src_q <= 1'b0;
      op1_pc_q <= 1'b0;
      alu_ctrl_o <= ADD;
      reg_write_o <= 1'b0;
      mem_read_o <= 1'b0;
      mem_write_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o <= valid_i;
      rs1_q <= rs1_addr_i;
      rs2_q <= rs2_addr_i;
      rd_addr_o <= rd_addr_i;
      rs1_data_q <= rs1_data_i;
      rs2_data_q <= rs2_data_i;
      imm_q <= imm_i;
      pc_q <= pc_i;
      alu_src_q <= alu_src_i;
      op1_pc_q <= op1_pc_i;
      alu_ctrl_o <= alu_ctrl_i;
      reg_write_o <= reg_write_i;
      mem_read_o <= mem_read_i;
      mem_write_o <= mem_write_i;
    end
  end
  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd1 (
    .rs(rs1_q), .rf_data(rs1_data_q),
    .exmem_rd(exmem_rd_i), .exmem_reg_write(exmem_reg_write_i), .exmem_result(exmem_result_i),
    .memwb_rd(memwb_rd_i), .memwb_reg_write(memwb_reg_write_i), .memwb_result(memwb_result_i),
    .sel(fwd1_sel), .data(fwd1_data)
  );
  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd2 (
    .rs(rs2_q), .rf_data(rs2_data_q),
    .exmem_rd(exmem_rd_i), .exmem_reg_write(exmem_reg_write_i), .exmem_result(exmem_result_i),
    .memwb_rd(memwb_rd_i), .memwb_reg_write(memwb_reg_write_i), .memwb_result(memwb_result_i),
    .sel(fwd2_sel), .data(fwd2_data)
  );
  assign unused_fwd = ^{fwd1_sel, fwd2_sel};
  assign alu_op1_o = op1_pc_q ? pc_q : fwd1_data;
  assign alu_op2_o = alu_src_q ? imm_q : fwd2_data;
  assign store_data_o = fwd2_data;
  // the load's data only exists after MEM, so a dependent instruction in decode must wait one cycle
  assign load_use_o = valid_o && mem_read_o && rd_addr_o != ADDR_WIDTH'(ZERO_REG) && valid_i &&
                      (rd_addr_o == rs1_addr_i || (uses_rs2_i && rd_addr_o == rs2_addr_i));
endmodule
